// File: rtl/des_pkg.sv
// DES constant tables and helpers shared by the iterative core.
// Vector bit 0 is DES bit 1, so a table entry n selects source index n-1.
package des_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Entry 0 of each box is the top nibble; entry = row*16 + column.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[k] = x[IP_T[k]-1];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 64; k++) y[k] = x[FP_T[k]-1];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[k] = x[E_T[k]-1];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int k = 0; k < 32; k++) y[k] = x[P_T[k]-1];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int k = 0; k < 56; k++) y[k] = x[PC1_T[k]-1];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int k = 0; k < 48; k++) y[k] = x[PC2_T[k]-1];
    return y;
  endfunction

  // six[0] is the first DES bit of the group; result is returned MSB-at-bit-0.
  function automatic logic [3:0] sbox_des(input int n, input logic [5:0] six);
    logic [5:0] idx;
    logic [3:0] v;
    idx = {six[0], six[5], six[1], six[2], six[3], six[4]};
    v = SBOX[n][255 - 4*int'(idx) -: 4];
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/des_feistel.sv
// One DES round: L' = R, R' = L ^ P(S(E(R) ^ K)).
module des_feistel
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);
  logic [47:0] x;
  logic [31:0] sv;

  always_comb begin
    x  = e_expand(r) ^ subkey;
    sv = '0;
    for (int j = 0; j < 8; j++) sv[4*j +: 4] = sbox_des(j, x[6*j +: 6]);
    r_next = l ^ p_perm(sv);
  end

  assign l_next = r;
endmodule

// File: rtl/des_key_step.sv
// One key-schedule step: rotate C/D (left for encrypt, right for decrypt) then PC2.
module des_key_step
  import des_pkg::*;
(
  input  logic [27:0] c,
  input  logic [27:0] d,
  input  logic        decrypt,
  input  logic [3:0]  round,
  output logic [27:0] c_next,
  output logic [27:0] d_next,
  output logic [47:0] subkey
);
  logic [1:0] amt;
  logic [3:0] di;

  // DES "left" rotation moves bit 1 toward bit 28, i.e. toward lower indices here.
  function automatic logic [27:0] rot(input logic [27:0] x, input logic left, input logic [1:0] n);
    case ({left, n})
      3'b101:  return {x[0], x[27:1]};
      3'b110:  return {x[1:0], x[27:2]};
      3'b001:  return {x[26:0], x[27]};
      3'b010:  return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  always_comb begin
    di  = 4'd0 - round;
    amt = 2'(SHIFT_T[round]);
    if (decrypt) amt = (round == 4'd0) ? 2'd0 : 2'(SHIFT_T[di]);
    c_next = rot(c, !decrypt, amt);
    d_next = rot(d, !decrypt, amt);
    subkey = pc2_perm({d_next, c_next});
  end
endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine: ROUNDS_PER_CYCLE chained rounds per clock, valid/ready on both sides.
module des_iter_core
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        decrypt,
  input  logic [63:0] key,
  input  logic [63:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dout,
  output logic        busy
);
  localparam int R = ROUNDS_PER_CYCLE;

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t      state, state_n;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic        mode;
  logic [4:0]  cnt, cnt_nxt;
  logic [63:0] dout_q, ipv;
  logic [55:0] pcv;

  logic [31:0] lc [R+1];
  logic [31:0] rc [R+1];
  logic [27:0] cc [R+1];
  logic [27:0] dc [R+1];
  logic [47:0] sk [R];

  assign lc[0] = l_q;
  assign rc[0] = r_q;
  assign cc[0] = c_q;
  assign dc[0] = d_q;

  for (genvar g = 0; g < R; g++) begin : g_round
    des_key_step u_ks (
      .c(cc[g]), .d(dc[g]), .decrypt(mode), .round(4'(cnt + 5'(g))),
      .c_next(cc[g+1]), .d_next(dc[g+1]), .subkey(sk[g])
    );
    des_feistel u_f (
      .l(lc[g]), .r(rc[g]), .subkey(sk[g]), .l_next(lc[g+1]), .r_next(rc[g+1])
    );
  end

  assign cnt_nxt = cnt + 5'(R);
  assign ipv     = ip_perm(din);
  assign pcv     = pc1_perm(key);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = RUN;
      RUN:     if (cnt_nxt == 5'd16) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_q <= '0; r_q <= '0; c_q <= '0; d_q <= '0;
      mode <= 1'b0; cnt <= '0; dout_q <= '0;
    end else if (state == IDLE && in_valid) begin
      l_q <= ipv[31:0];  r_q <= ipv[63:32];
      c_q <= pcv[27:0];  d_q <= pcv[55:28];
      mode <= decrypt;   cnt <= '0;
    end else if (state == RUN) begin
      l_q <= lc[R]; r_q <= rc[R];
      c_q <= cc[R]; d_q <= dc[R];
      cnt <= cnt_nxt;
      // Preoutput is R16 then L16 in DES bit order.
      if (cnt_nxt == 5'd16) dout_q <= fp_perm({lc[R], rc[R]});
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign dout      = dout_q;
endmodule

// File: tb/tb_des_iter_core.sv
// Directed and random checks of des_iter_core at every legal rounds-per-cycle.
module tb_des_iter_core;
  import des_pkg::*;

  localparam int ND = 5;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, decrypt = 1'b0, out_ready = 1'b0;
  logic [63:0] key = '0, din = '0;
  logic [ND-1:0] in_ready_v, out_valid_v, busy_v;
  logic [63:0] dout_v [ND];
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[g]),
      .decrypt(decrypt), .key(key), .din(din), .out_valid(out_valid_v[g]),
      .out_ready(out_ready), .dout(dout_v[g]), .busy(busy_v[g])
    );
  end

  typedef struct {
    logic        dec;
    logic [63:0] k;
    logic [63:0] blk;
    logic [63:0] exp;
  } vec_t;

  // Vectors are written in conventional DES hex (bit 1 = MSB); the DUT is LSB-first.
  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[63-i];
    return y;
  endfunction

  // Textbook DES in MSB-first numbering; decrypt reuses encrypt subkeys reversed.
  function automatic logic [63:0] des_model(input logic [63:0] k, input logic [63:0] blk, input logic dec);
    logic [55:0] pc, cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [47:0] e, x;
    logic [63:0] v, o, pre;
    logic [31:0] l, r, t, sv, p;
    logic [5:0]  six;
    for (int kk = 0; kk < 56; kk++) pc[55-kk] = k[64-PC1_T[kk]];
    c = pc[55:28];
    d = pc[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < SHIFT_T[i]; n++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int kk = 0; kk < 48; kk++) ks[i][47-kk] = cd[56-PC2_T[kk]];
    end
    for (int kk = 0; kk < 64; kk++) v[63-kk] = blk[64-IP_T[kk]];
    l = v[63:32];
    r = v[31:0];
    for (int i = 0; i < 16; i++) begin
      for (int kk = 0; kk < 48; kk++) e[47-kk] = r[32-E_T[kk]];
      x = e ^ (dec ? ks[15-i] : ks[i]);
      for (int j = 0; j < 8; j++) begin
        six = x[47-6*j -: 6];
        sv[31-4*j -: 4] = SBOX[j][255 - 4*(int'({six[5], six[0]})*16 + int'(six[4:1])) -: 4];
      end
      for (int kk = 0; kk < 32; kk++) p[31-kk] = sv[32-P_T[kk]];
      t = r;
      r = l ^ p;
      l = t;
    end
    pre = {r, l};
    for (int kk = 0; kk < 64; kk++) o[63-kk] = pre[64-FP_T[kk]];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Wait for DUT g to be idle, present one block, return just after the accept edge.
  task automatic start(input int g, input logic [63:0] k, input logic [63:0] b, input logic dec);
    int w = 0;
    out_ready = 1'b1; in_valid = 1'b0;
    while (!in_ready_v[g] && w < 50) begin step(); w++; end
    if (w >= 50) chk("in_ready_timeout", 64'(in_ready_v[g]), 64'd1);
    out_ready = 1'b0; in_valid = 1'b1; key = k; din = b; decrypt = dec;
    step();
    in_valid = 1'b0; key = {$urandom, $urandom}; din = {$urandom, $urandom}; decrypt = ~dec;
  endtask

  task automatic wait_done(input int g, output int lat);
    lat = 0;
    while (!out_valid_v[g] && lat < 40) begin step(); lat++; end
  endtask

  task automatic run_op(input int g, input logic [63:0] k, input logic [63:0] b, input logic dec,
                        output logic [63:0] res, output int lat);
    start(g, k, b, dec);
    wait_done(g, lat);
    res = dout_v[g];
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  vec_t tv [10];
  logic [63:0] res, exp_s, k_s, b_s;
  int lat;
  int first [ND];
  int seen;

  initial begin
    tv[0] = '{1'b0, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405};
    tv[1] = '{1'b0, 64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0000000000000000};
    tv[2] = '{1'b0, 64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7};
    tv[3] = '{1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58};
    tv[4] = '{1'b0, 64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815};
    for (int i = 0; i < 5; i++) tv[i+5] = '{1'b1, tv[i].k, tv[i].exp, tv[i].blk};

    step();
    do_reset();
    chk("rst_in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("rst_busy", 64'(busy_v[0]), 64'd0);
    chk("rst_dout", dout_v[0], 64'd0);

    // Known-answer table, rotated across all rounds-per-cycle settings
    for (int i = 0; i < 10; i++) begin
      run_op(i % ND, rev64(tv[i].k), rev64(tv[i].blk), tv[i].dec, res, lat);
      chk($sformatf("kat%0d_dout", i), rev64(res), tv[i].exp);
      chk($sformatf("kat%0d_latency", i), 64'(lat), 64'(16 >> (i % ND)));
    end

    // Completion with out_ready held low; in_valid pulses must be ignored
    start(0, rev64(tv[0].k), rev64(tv[0].blk), 1'b0);
    wait_done(0, lat);
    chk("stall_latency", 64'(lat), 64'd16);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1;
      din = {$urandom, $urandom};
      step();
      chk($sformatf("stall%0d_dout", c), rev64(dout_v[0]), tv[0].exp);
      chk($sformatf("stall%0d_out_valid", c), 64'(out_valid_v[0]), 64'd1);
      chk($sformatf("stall%0d_in_ready", c), 64'(in_ready_v[0]), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall_release_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("stall_release_in_ready", 64'(in_ready_v[0]), 64'd1);

    // Reset in the 7th RUN cycle discards the block
    start(0, rev64(tv[4].k), rev64(tv[4].blk), 1'b0);
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("midrst_dout", dout_v[0], 64'd0);
    chk("midrst_in_ready", 64'(in_ready_v[0]), 64'd1);
    chk("midrst_busy", 64'(busy_v[0]), 64'd0);
    seen = 0;
    repeat (20) begin step(); if (out_valid_v[0]) seen++; end
    chk("midrst_no_output", 64'(seen), 64'd0);
    run_op(0, rev64(tv[0].k), rev64(tv[0].blk), 1'b0, res, lat);
    chk("midrst_next_dout", rev64(res), tv[0].exp);

    // Back-to-back: out_ready high at completion, next block waiting on in_valid
    start(0, rev64(tv[0].k), rev64(tv[0].blk), 1'b0);
    out_ready = 1'b1; in_valid = 1'b1;
    key = rev64(tv[4].k); din = rev64(tv[4].blk); decrypt = 1'b0;
    wait_done(0, lat);
    chk("b2b_a_dout", rev64(dout_v[0]), tv[0].exp);
    step();
    chk("b2b_idle_in_ready", 64'(in_ready_v[0]), 64'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_accept_busy", 64'(busy_v[0]), 64'd1);
    wait_done(0, lat);
    chk("b2b_b_latency", 64'(lat), 64'd16);
    chk("b2b_b_dout", rev64(dout_v[0]), tv[4].exp);
    step();
    out_ready = 1'b0;

    // Same decrypt on every configuration at once; each finishes after 16/R cycles
    do_reset();
    key = rev64(64'h133457799BBCDFF1); din = rev64(64'h85E813540F0AB405);
    decrypt = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int g = 0; g < ND; g++) first[g] = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      for (int g = 0; g < ND; g++) if (first[g] < 0 && out_valid_v[g]) first[g] = c;
    end
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("rpc%0d_latency", 1 << g), 64'(first[g]), 64'(16 >> g));
      chk($sformatf("rpc%0d_dout", 1 << g), rev64(dout_v[g]), 64'h0123456789ABCDEF);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Random keys/blocks against the reference model, both modes
    for (int i = 0; i < 1000; i++) begin
      k_s = {$urandom, $urandom};
      b_s = {$urandom, $urandom};
      exp_s = des_model(k_s, b_s, 1'b0);
      run_op(i % ND, rev64(k_s), rev64(b_s), 1'b0, res, lat);
      chk($sformatf("rand%0d_enc", i), rev64(res), exp_s);
      b_s = {$urandom, $urandom};
      exp_s = des_model(k_s, b_s, 1'b1);
      run_op(i % ND, rev64(k_s), rev64(b_s), 1'b1, res, lat);
      chk($sformatf("rand%0d_dec", i), rev64(res), exp_s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/des_iter_core.md
DES_ITER_CORE -- requirements
Module: des_iter_core

Interface
REQ-001 The block SHALL have parameter ROUNDS_PER_CYCLE, default 1: Feistel rounds computed per clock; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  din/key/decrypt valid this cycle.
REQ-005 in_ready  output  1  core can accept a block.
REQ-006 decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-007 key  input  64  DES key, bit [0] = DES bit 1; parity bits ignored.
REQ-008 din  input  64  plaintext/ciphertext block, bit [0] = DES bit 1.
REQ-009 out_valid  output  1  dout holds a finished result.
REQ-010 out_ready  input  1  consumer accepts dout.
REQ-011 dout  output  64  result block, bit [0] = DES bit 1.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 The core SHALL have states IDLE, RUN and DONE.
REQ-014 Accept SHALL occur when in_valid and in_ready are both high; in_ready SHALL be high only in IDLE.
REQ-015 On accept, the core SHALL register IP(din) as L0/R0, PC1(key) as C0/D0, latch the mode, clear the round counter and go to RUN.
REQ-016 In RUN, each cycle SHALL apply ROUNDS_PER_CYCLE chained rounds: L'=R, R'=L xor f(R,Ki), with f = E-expand, xor subkey, S1..S8, P.
REQ-017 Encrypt: subkey Ki = PC2(C,D) after left-rotating C and D by shift[i] (1 for rounds 1, 2, 9, 16; otherwise 2).
REQ-018 Decrypt: the first subkey SHALL be PC2(C0,D0); before each later round j = 2..16, C and D SHALL be right-rotated by shift[18-j].
REQ-019 The 5-bit round counter SHALL advance by ROUNDS_PER_CYCLE per cycle; once it reaches 16, the state SHALL become DONE.
REQ-020 Latency: accept in cycle t gives out_valid high in cycle t + 16/ROUNDS_PER_CYCLE.
REQ-021 On entering DONE, dout SHALL be loaded with FP(R16,L16) (halves swapped).
REQ-022 In DONE, dout and out_valid SHALL stay stable until out_ready is high; that cycle SHALL return the core to IDLE.
REQ-023 in_valid in RUN or DONE SHALL be ignored; no data is lost, because in_ready is low.
REQ-024 out_ready while not in DONE SHALL have no effect.
REQ-025 Changes to key, din or decrypt after accept SHALL NOT affect the block in flight.

Reset
REQ-026 When rst is high at a clock edge, the core SHALL go to IDLE, clear the round counter and data registers, and set out_valid=0, busy=0, dout=0 and in_ready=1 from the next cycle.
REQ-027 rst SHALL take priority over accept and completion in the same cycle; an operation in flight SHALL be discarded with no output.

Structure
REQ-028 A shared package des_pkg SHALL hold the IP, FP, E, P, PC1 and PC2 tables, the S-box contents, the shift schedule and the state encoding.
REQ-029 The existing feistel round-function block SHALL be instantiated ROUNDS_PER_CYCLE times; the key-schedule step SHALL be a sub-module des_key_step (one rotate plus PC2 per round, direction set by mode).
REQ-030 An illegal ROUNDS_PER_CYCLE SHALL cause an elaboration-time error.

Verification
REQ-031 Encrypt, key 133457799BBCDFF1, din 0123456789ABCDEF -> dout 85E813540F0AB405; out_valid 16 cycles after accept (R=1).
REQ-032 Decrypt, same key, din 85E813540F0AB405 -> dout 0123456789ABCDEF; repeat with R=1, 2, 4, 8, 16 and check latency 16/R.
REQ-033 out_ready held low 5 cycles after completion -> dout/out_valid stable; in_valid pulses ignored; in_ready low throughout.
REQ-034 rst asserted in cycle 7 of RUN -> next cycle IDLE, out_valid=0, dout=0; a new block then produces a correct result.
REQ-035 Back-to-back: out_ready=1 at completion and in_valid held -> next accept one cycle later (IDLE); 1000 random key/data pairs match the golden model in both modes.
